// File: rtl/l2_req_arb_pkg.sv
// rtl/l2_req_arb_pkg.sv - shared memory request/response types and l2 arbiter defaults
package l2_req_arb_pkg;

    localparam int L2_MAX_OUTSTANDING_DEF = 4;
    localparam int L2_STARVE_LIMIT_DEF    = 8;

    typedef enum logic {
        L2_SRC_IC = 1'b0,
        L2_SRC_DC = 1'b1
    } t_l2_src;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [1:0]  cmd;
    } t_mem_req_pkt;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
    } t_mem_rsp_pkt;

endpackage

// File: rtl/l2_src_fifo.sv
// rtl/l2_src_fifo.sv - in-order FIFO of request sources awaiting an l2 response
module l2_src_fifo
    import l2_req_arb_pkg::*;
#(
    parameter int  DEPTH = L2_MAX_OUTSTANDING_DEF,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  t_l2_src       push_src,
    input  logic          pop,
    output t_l2_src       head,
    output logic          empty,
    output logic [CW-1:0] cnt
);

    t_l2_src       mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_src;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

`ifdef ASSERT
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && full));
        end
    end
`endif

endmodule

// File: rtl/l2_req_arb.sv
// rtl/l2_req_arb.sv - round-robin IC/DC arbiter onto the l2 request port with response routing
module l2_req_arb
    import l2_req_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = L2_MAX_OUTSTANDING_DEF,
    parameter int STARVE_LIMIT    = L2_STARVE_LIMIT_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ic_req_valid,
    input  t_mem_req_pkt ic_req_pkt,
    output logic         ic_req_ready,
    input  logic         dc_req_valid,
    input  t_mem_req_pkt dc_req_pkt,
    output logic         dc_req_ready,
    output logic         l2_req_valid,
    output t_mem_req_pkt l2_req_pkt,
    input  logic         l2_req_ready,
    input  logic         l2_rsp_valid,
    input  t_mem_rsp_pkt l2_rsp_pkt,
    output logic         ic_rsp_valid,
    output t_mem_rsp_pkt ic_rsp_pkt,
    output logic         dc_rsp_valid,
    output t_mem_rsp_pkt dc_rsp_pkt
);

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic          slot_free;
    logic          can_grant;
    logic          ic_win;
    logic          dc_win;
    logic          grant;
    logic          rsp_pop;
    t_l2_src       rr_last;
    t_l2_src       win_src;
    t_l2_src       head;
    logic          empty;
    logic [CW-1:0] cnt;
    logic [SW-1:0] ic_starve;
    logic [SW-1:0] dc_starve;

    assign slot_free = !l2_req_valid || l2_req_ready;
    // a pop in this cycle is not counted: the tag slot frees only next cycle
    assign can_grant = !reset && slot_free && (cnt < CW'(MAX_OUTSTANDING));

    always_comb begin
        ic_win = 1'b0;
        dc_win = 1'b0;
        if (can_grant) begin
            if (ic_req_valid && dc_req_valid) begin
                if (dc_starve == STARVE_MAX) begin
                    dc_win = 1'b1;
                end else if (ic_starve == STARVE_MAX) begin
                    ic_win = 1'b1;
                end else if (rr_last == L2_SRC_IC) begin
                    dc_win = 1'b1;
                end else begin
                    ic_win = 1'b1;
                end
            end else begin
                ic_win = ic_req_valid;
                dc_win = dc_req_valid;
            end
        end
    end

    assign grant        = ic_win || dc_win;
    assign win_src      = dc_win ? L2_SRC_DC : L2_SRC_IC;
    assign ic_req_ready = ic_win;
    assign dc_req_ready = dc_win;

    always_ff @(posedge clk) begin
        if (reset) begin
            l2_req_valid <= 1'b0;
            l2_req_pkt   <= '0;
            rr_last      <= L2_SRC_IC;
        end else if (grant) begin
            l2_req_valid <= 1'b1;
            l2_req_pkt   <= dc_win ? dc_req_pkt : ic_req_pkt;
            rr_last      <= win_src;
        end else if (l2_req_ready) begin
            l2_req_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !ic_req_valid || ic_win) begin
            ic_starve <= '0;
        end else if (dc_win && ic_starve != STARVE_MAX) begin
            ic_starve <= ic_starve + SW'(1);
        end
        if (reset || !dc_req_valid || dc_win) begin
            dc_starve <= '0;
        end else if (ic_win && dc_starve != STARVE_MAX) begin
            dc_starve <= dc_starve + SW'(1);
        end
    end

    l2_src_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_src_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (grant),
        .push_src (win_src),
        .pop      (rsp_pop),
        .head     (head),
        .empty    (empty),
        .cnt      (cnt)
    );

    // responses with no tag outstanding are dropped
    assign rsp_pop      = !reset && l2_rsp_valid && !empty;
    assign ic_rsp_valid = rsp_pop && (head == L2_SRC_IC);
    assign dc_rsp_valid = rsp_pop && (head == L2_SRC_DC);
    assign ic_rsp_pkt   = l2_rsp_pkt;
    assign dc_rsp_pkt   = l2_rsp_pkt;

`ifdef ASSERT
    logic         held_q;
    t_mem_req_pkt held_pkt_q;
    always_ff @(posedge clk) begin
        held_q     <= !reset && l2_req_valid && !l2_req_ready;
        held_pkt_q <= l2_req_pkt;
        if (!reset) begin
            assert (!(ic_req_ready && dc_req_ready));
            assert (!(l2_rsp_valid && empty));
            if (held_q) begin
                assert (l2_req_pkt == held_pkt_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_l2_req_arb.sv
// tb/tb_l2_req_arb.sv - directed bench for l2_req_arb with a per-cycle reference model
module tb_l2_req_arb;
    import l2_req_arb_pkg::*;

    localparam int MAXO = 4;
    localparam int SL   = 2;

    logic         clk;
    logic         reset;
    logic         ic_req_valid;
    t_mem_req_pkt ic_req_pkt;
    logic         ic_req_ready;
    logic         dc_req_valid;
    t_mem_req_pkt dc_req_pkt;
    logic         dc_req_ready;
    logic         l2_req_valid;
    t_mem_req_pkt l2_req_pkt;
    logic         l2_req_ready;
    logic         l2_rsp_valid;
    t_mem_rsp_pkt l2_rsp_pkt;
    logic         ic_rsp_valid;
    t_mem_rsp_pkt ic_rsp_pkt;
    logic         dc_rsp_valid;
    t_mem_rsp_pkt dc_rsp_pkt;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit auto_rsp    = 0;
    bit force_rr_dc = 0;
    int pend[$];
    int glog[$];
    int rlog[$];

    l2_req_arb #(
        .MAX_OUTSTANDING (MAXO),
        .STARVE_LIMIT    (SL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ic_req_valid (ic_req_valid),
        .ic_req_pkt   (ic_req_pkt),
        .ic_req_ready (ic_req_ready),
        .dc_req_valid (dc_req_valid),
        .dc_req_pkt   (dc_req_pkt),
        .dc_req_ready (dc_req_ready),
        .l2_req_valid (l2_req_valid),
        .l2_req_pkt   (l2_req_pkt),
        .l2_req_ready (l2_req_ready),
        .l2_rsp_valid (l2_rsp_valid),
        .l2_rsp_pkt   (l2_rsp_pkt),
        .ic_rsp_valid (ic_rsp_valid),
        .ic_rsp_pkt   (ic_rsp_pkt),
        .dc_rsp_valid (dc_rsp_valid),
        .dc_rsp_pkt   (dc_rsp_pkt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic t_mem_req_pkt mk_pkt(input int src, input int n);
        t_mem_req_pkt p;
        p.addr = 32'h1000_0000 + 32'(src << 24) + 32'(n);
        p.id   = 4'(n);
        p.cmd  = 2'(src + 1);
        return p;
    endfunction

    // reference model: outstanding sources as a queue, evaluated at every negedge
    bit           m_l2v;
    t_mem_req_pkt m_pkt;
    int           m_rr;
    int           m_ic_st;
    int           m_dc_st;
    int           m_q[$];

    initial begin
        m_l2v = 0; m_pkt = '0; m_rr = 0; m_ic_st = 0; m_dc_st = 0;
    end

    always @(negedge clk) begin
        bit can, gi, gd, ei, ed;
        int rr;
        rr  = force_rr_dc ? 1 : m_rr;
        can = !reset && (!m_l2v || l2_req_ready) && (m_q.size() < MAXO);
        gi  = 0;
        gd  = 0;
        if (can) begin
            if (ic_req_valid && dc_req_valid) begin
                if (m_dc_st == SL)      gd = 1;
                else if (m_ic_st == SL) gi = 1;
                else if (rr == 0)       gd = 1;
                else                    gi = 1;
            end else begin
                gi = ic_req_valid;
                gd = dc_req_valid;
            end
        end
        ei = !reset && l2_rsp_valid && m_q.size() > 0 && m_q[0] == 0;
        ed = !reset && l2_rsp_valid && m_q.size() > 0 && m_q[0] == 1;
        chk("m_ic_req_ready", 64'(ic_req_ready), 64'(gi));
        chk("m_dc_req_ready", 64'(dc_req_ready), 64'(gd));
        chk("m_l2_req_valid", 64'(l2_req_valid), 64'(m_l2v));
        chk("m_l2_req_pkt", 64'(l2_req_pkt), 64'(m_pkt));
        chk("m_ic_rsp_valid", 64'(ic_rsp_valid), 64'(ei));
        chk("m_dc_rsp_valid", 64'(dc_rsp_valid), 64'(ed));
        if (ei) chk("m_ic_rsp_pkt", 64'(ic_rsp_pkt), 64'(l2_rsp_pkt));
        if (ed) chk("m_dc_rsp_pkt", 64'(dc_rsp_pkt), 64'(l2_rsp_pkt));
        if (reset) begin
            m_l2v = 0; m_pkt = '0; m_rr = 0; m_ic_st = 0; m_dc_st = 0;
            m_q.delete();
        end else begin
            if (l2_rsp_valid && m_q.size() > 0) void'(m_q.pop_front());
            if (gi || gd) begin
                m_q.push_back(gd ? 1 : 0);
                m_pkt = gd ? dc_req_pkt : ic_req_pkt;
                m_l2v = 1;
                m_rr  = gd ? 1 : 0;
            end else if (l2_req_ready) begin
                m_l2v = 0;
            end
            if (force_rr_dc) m_rr = 1;
            if (!ic_req_valid || gi)    m_ic_st = 0;
            else if (gd && m_ic_st < SL) m_ic_st = m_ic_st + 1;
            if (!dc_req_valid || gd)    m_dc_st = 0;
            else if (gi && m_dc_st < SL) m_dc_st = m_dc_st + 1;
        end
    end

    // one clock; the l2 stand-in answers each taken request two cycles later
    task automatic tick();
        #1;
        if (auto_rsp && l2_req_valid && l2_req_ready) pend.push_back(cyc + 2);
        @(posedge clk);
        #1;
        cyc++;
        if (auto_rsp) begin
            l2_rsp_valid = 1'b0;
            if (pend.size() > 0 && pend[0] == cyc) begin
                l2_rsp_valid = 1'b1;
                l2_rsp_pkt   = '{id: 4'(cyc), data: 32'(cyc) ^ 32'h5a5a_0000};
                void'(pend.pop_front());
            end
        end
    endtask

    task automatic log_cycle();
        if (dc_req_ready)      glog.push_back(1);
        else if (ic_req_ready) glog.push_back(0);
        if (ic_rsp_valid) rlog.push_back(0);
        if (dc_rsp_valid) rlog.push_back(1);
    endtask

    int n;
    int exp_alt[4]  = '{1, 0, 1, 0};
    int exp_stv[6]  = '{0, 0, 1, 0, 0, 1};

    initial begin
        reset        = 1'b1;
        ic_req_valid = 1'b1;
        dc_req_valid = 1'b1;
        ic_req_pkt   = mk_pkt(0, 0);
        dc_req_pkt   = mk_pkt(1, 0);
        l2_req_ready = 1'b1;
        l2_rsp_valid = 1'b0;
        l2_rsp_pkt   = '0;

        // reset with both requesters valid
        repeat (3) begin
            @(negedge clk);
            chk("rst_ic_ready", 64'(ic_req_ready), 64'd0);
            chk("rst_dc_ready", 64'(dc_req_ready), 64'd0);
            chk("rst_l2_valid", 64'(l2_req_valid), 64'd0);
            tick();
        end
        reset    = 1'b0;
        auto_rsp = 1'b1;

        // both valid continuously: alternating grants starting with DC
        for (int i = 0; i < 8; i++) begin
            ic_req_pkt = mk_pkt(0, i);
            dc_req_pkt = mk_pkt(1, i);
            @(negedge clk);
            if (i == 0) begin
                chk("first_dc_ready", 64'(dc_req_ready), 64'd1);
                chk("first_ic_ready", 64'(ic_req_ready), 64'd0);
            end
            if (i == 1) begin
                chk("first_l2_valid", 64'(l2_req_valid), 64'd1);
                chk("first_l2_pkt", 64'(l2_req_pkt), 64'(mk_pkt(1, 0)));
            end
            log_cycle();
            tick();
        end
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            log_cycle();
            tick();
        end
        auto_rsp     = 1'b0;
        l2_rsp_valid = 1'b0;
        chk("alt_grant_count", 64'(glog.size()), 64'd8);
        chk("alt_rsp_count", 64'(rlog.size()), 64'd8);
        for (int i = 0; i < 4; i++) begin
            chk("alt_grant_src", 64'(glog[i]), 64'(exp_alt[i]));
            chk("alt_rsp_route", 64'(rlog[i]), 64'(exp_alt[i]));
        end

        // only IC valid, no responses: tag FIFO fills after 4 grants
        ic_req_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            ic_req_pkt = mk_pkt(0, 16 + i);
            @(negedge clk);
            n += int'(ic_req_ready);
            if (i == 7) chk("full_ic_ready", 64'(ic_req_ready), 64'd0);
            tick();
        end
        chk("full_grant_count", 64'(n), 64'd4);
        l2_rsp_valid = 1'b1;
        l2_rsp_pkt   = '{id: 4'd1, data: 32'hcafe_0001};
        @(negedge clk);
        chk("full_rsp_ic", 64'(ic_rsp_valid), 64'd1);
        chk("full_rsp_dc", 64'(dc_rsp_valid), 64'd0);
        chk("full_pop_no_grant", 64'(ic_req_ready), 64'd0);
        tick();
        l2_rsp_valid = 1'b0;
        @(negedge clk);
        chk("full_resume", 64'(ic_req_ready), 64'd1);
        tick();
        ic_req_valid = 1'b0;
        l2_rsp_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("full_drain_rsp", 64'(ic_rsp_valid), 64'd1);
            tick();
        end
        l2_rsp_valid = 1'b0;

        // l2 back-pressure: held request stays bit-stable
        l2_req_ready = 1'b0;
        ic_req_valid = 1'b1;
        ic_req_pkt   = mk_pkt(0, 40);
        @(negedge clk);
        chk("hold_first_grant", 64'(ic_req_ready), 64'd1);
        tick();
        ic_req_pkt = mk_pkt(0, 41);
        repeat (5) begin
            @(negedge clk);
            chk("hold_pkt", 64'(l2_req_pkt), 64'(mk_pkt(0, 40)));
            chk("hold_valid", 64'(l2_req_valid), 64'd1);
            chk("hold_no_ready", 64'(ic_req_ready), 64'd0);
            tick();
        end
        l2_req_ready = 1'b1;
        @(negedge clk);
        chk("hold_drain_grant", 64'(ic_req_ready), 64'd1);
        tick();
        ic_req_valid = 1'b0;
        @(negedge clk);
        chk("hold_next_pkt", 64'(l2_req_pkt), 64'(mk_pkt(0, 41)));
        tick();
        l2_rsp_valid = 1'b1;
        repeat (2) tick();
        l2_rsp_valid = 1'b0;

        // rr pointer pinned toward IC: DC wins after SL losses
        force dut.rr_last = L2_SRC_DC;
        force_rr_dc  = 1'b1;
        ic_req_valid = 1'b1;
        dc_req_valid = 1'b1;
        auto_rsp     = 1'b1;
        glog.delete();
        for (int i = 0; i < 6; i++) begin
            ic_req_pkt = mk_pkt(0, 48 + i);
            dc_req_pkt = mk_pkt(1, 48 + i);
            @(negedge clk);
            if (i == 2) chk("starve_at_limit", 64'(dut.dc_starve), 64'd2);
            if (i == 3) chk("starve_cleared", 64'(dut.dc_starve), 64'd0);
            log_cycle();
            tick();
        end
        release dut.rr_last;
        force_rr_dc = 1'b0;
        chk("starve_grant_count", 64'(glog.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            chk("starve_grant_src", 64'(glog[i]), 64'(exp_stv[i]));
        end
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        repeat (5) tick();
        auto_rsp     = 1'b0;
        l2_rsp_valid = 1'b0;

        // pointer wrap: reset, then push/pop mixes that land wr_ptr on 3 at cnt 4
        reset        = 1'b1;
        ic_req_valid = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("wrap_a0_grant", 64'(ic_req_ready), 64'd1);
        tick();
        l2_rsp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wrap_pp_grant", 64'(ic_req_ready), 64'd1);
            tick();
            if (i == 0) chk("wrap_pp_cnt", 64'(dut.u_src_fifo.cnt), 64'd1);
        end
        l2_rsp_valid = 1'b0;
        repeat (3) tick();
        chk("wrap_wr3", 64'(dut.u_src_fifo.wr_ptr), 64'd3);
        chk("wrap_rd3", 64'(dut.u_src_fifo.rd_ptr), 64'd3);
        chk("wrap_cnt4", 64'(dut.u_src_fifo.cnt), 64'd4);
        l2_rsp_valid = 1'b1;
        @(negedge clk);
        chk("wrap_full_no_grant", 64'(ic_req_ready), 64'd0);
        chk("wrap_rsp_ic", 64'(ic_rsp_valid), 64'd1);
        tick();
        l2_rsp_valid = 1'b0;
        chk("wrap_rd0", 64'(dut.u_src_fifo.rd_ptr), 64'd0);
        chk("wrap_cnt3", 64'(dut.u_src_fifo.cnt), 64'd3);
        @(negedge clk);
        chk("wrap_regrant", 64'(ic_req_ready), 64'd1);
        tick();
        chk("wrap_wr0", 64'(dut.u_src_fifo.wr_ptr), 64'd0);
        chk("wrap_cnt4_again", 64'(dut.u_src_fifo.cnt), 64'd4);
        ic_req_valid = 1'b0;
        l2_rsp_valid = 1'b1;
        repeat (4) tick();
        l2_rsp_valid = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
